// File: rtl/cbu8_up_counter_pkg.sv
// Shared definitions for the cascadable up-counter: default width, the
// per-edge operation encoding and the terminal-value compare helper.
package cbu_pkg;

  localparam int CBU_DEF_WIDTH = 8;

  // Operation selected at each rising clock edge, highest priority first:
  // clear, load, count, hold.
  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_CLR  = 2'd1,
    OP_LOAD = 2'd2,
    OP_CNT  = 2'd3
  } cbu_op_e;

  // Terminal-value compare. Operands are zero-extended to 32 bits by the
  // caller so one helper serves every legal width (2..32).
  function automatic logic cbu_is_term(input logic [31:0] q, input logic [31:0] t);
    return (q == t);
  endfunction

endpackage

// File: rtl/cbu8_up_counter_if.sv
// Counter bus: control inputs, load data, optional modulo value and the
// count/carry/terminal outputs. The MOD signal exists only when
// CBU_MODULO_EN is defined.
interface cbu8_up_counter_if
  import cbu_pkg::*;
#(
  parameter int WIDTH = CBU_DEF_WIDTH
) ();

  logic             EN;
  logic             CAI;
  logic             LD;
  logic [WIDTH-1:0] D;
`ifdef CBU_MODULO_EN
  logic [WIDTH-1:0] MOD;
`endif
  logic [WIDTH-1:0] Q;
  logic             CAO;
  logic             TC;

  modport master (
`ifdef CBU_MODULO_EN
    output MOD,
`endif
    output EN, CAI, LD, D,
    input  Q, CAO, TC
  );

  modport slave (
`ifdef CBU_MODULO_EN
    input  MOD,
`endif
    input  EN, CAI, LD, D,
    output Q, CAO, TC
  );

endinterface

// File: rtl/cbu8_up_counter_nibble.sv
// Up to 4-bit incrementer slice. The slice carry-out is a direct AND of the
// slice bits with the incoming carry (local lookahead), so carries only
// ripple slice-to-slice, never bit-to-bit.
module cbu_nibble #(
  parameter int SW = 4
) (
  input  logic [SW-1:0] q,
  input  logic          ci,
  input  logic          en,
  output logic [SW-1:0] q_inc,
  output logic          co
);

  logic inc;

  // Increment the slice when enabled with an incoming carry; lookahead carry-out.
  always_comb begin
    inc   = ci & en;
    q_inc = q + SW'(inc);
    co    = inc & (&q);
  end

endmodule

// File: rtl/cbu8_up_counter.sv
// Cascadable WIDTH-bit up counter with async clear, sync parallel load,
// enable, carry-in and combinational carry-out; TC is a registered
// terminal-count flag.
// Macros:
//   CBU_MODULO_EN - adds the MOD port; terminal value becomes MOD and the
//                   count wraps to 0 after reaching it.
//   CBU_X_CHECK   - simulation-only: unknown EN/CAI/LD drives Q to X and
//                   prints a message.
module cbu8_up_counter
  import cbu_pkg::*;
#(
  parameter int WIDTH    = CBU_DEF_WIDTH,
  parameter bit LOAD_PRI = 1'b1
) (
  input logic               CLK,
  input logic               CDN,
  cbu8_up_counter_if.slave  bus
);

  localparam int NSL = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             tc_q;
  logic             tc_d;

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] inc;
  logic [NSL:0]     carry;
  logic             load_req;
  logic             cnt_req;
  logic             at_term;
  logic             cao;
  logic [31:0]      q_ext;
  logic [31:0]      qd_ext;
  logic [31:0]      t_ext;
  cbu_op_e          op;

`ifdef CBU_MODULO_EN
  assign term = bus.MOD;
`else
  assign term = {WIDTH{1'b1}};
`endif

  // Slice chain: carry[0] injects the +1, each slice hands its carry upward.
  assign carry[0] = 1'b1;

  for (genvar k = 0; k < NSL; k++) begin : g_slice
    localparam int SW = ((WIDTH - 4 * k) > 4) ? 4 : (WIDTH - 4 * k);
    cbu_nibble #(.SW(SW)) u_nib (
      .q     (q_q[4*k +: SW]),
      .ci    (carry[k]),
      .en    (cnt_req),
      .q_inc (inc[4*k +: SW]),
      .co    (carry[k+1])
    );
  end

  // Priority decode of the operation for the coming edge.
  always_comb begin
    load_req = bus.LD & (LOAD_PRI ? 1'b1 : bus.EN);
    cnt_req  = bus.EN & bus.CAI;
    op       = OP_HOLD;
    if (!CDN) begin
      op = OP_CLR;
    end else if (load_req) begin
      op = OP_LOAD;
    end else if (cnt_req) begin
      op = OP_CNT;
    end else begin
      op = OP_HOLD;
    end
  end

  // Next count value and next terminal flag (TC mirrors next Q against T).
  always_comb begin
    q_ext              = 32'd0;
    t_ext              = 32'd0;
    q_ext[WIDTH-1:0]   = q_q;
    t_ext[WIDTH-1:0]   = term;
    at_term            = cbu_is_term(q_ext, t_ext);
    q_d                = q_q;
    case (op)
      OP_LOAD: q_d = bus.D;
      OP_CNT:  q_d = at_term ? {WIDTH{1'b0}} : inc;
      OP_CLR:  q_d = {WIDTH{1'b0}};
      default: q_d = q_q;
    endcase
`ifdef CBU_X_CHECK
    if ($isunknown({bus.EN, bus.CAI, bus.LD})) begin
      q_d = {WIDTH{1'bx}};
    end else begin
      q_d = q_d;
    end
`endif
    qd_ext             = 32'd0;
    qd_ext[WIDTH-1:0]  = q_d;
    tc_d               = cbu_is_term(qd_ext, t_ext);
  end

  // Carry-out: only on a genuine count cycle at the terminal value, so a
  // load cycle or a cleared counter never advances the upper stages.
  always_comb begin
    cao = 1'b0;
    if (op == OP_CNT) begin
`ifdef CBU_MODULO_EN
      cao = at_term;
`else
      cao = carry[NSL];
`endif
    end else begin
      cao = 1'b0;
    end
  end

  // Count and terminal-flag registers with asynchronous clear.
  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      q_q  <= {WIDTH{1'b0}};
      tc_q <= 1'b0;
    end else begin
      q_q  <= q_d;
      tc_q <= tc_d;
    end
  end

`ifdef CBU_X_CHECK
  // Debug aid: report unknown control inputs at each edge.
  always @(posedge CLK) begin
    if ($isunknown({bus.EN, bus.CAI, bus.LD})) begin
      $display("cbu8_up_counter %m: unknown EN/CAI/LD at time %0t", $time);
    end
  end
`endif

  assign bus.Q   = q_q;
  assign bus.CAO = cao;
  assign bus.TC  = tc_q;

endmodule

// File: tb/tb_cbu8_up_counter.sv
// Self-checking bench for cbu8_up_counter: directed scenarios plus a
// randomized run compared against an arithmetic reference model.
module tb_cbu8_up_counter;

  localparam int W = 8;

  logic CLK = 1'b0;
  logic CDN;
  int   checks = 0;
  int   errors = 0;
  int   cur_mod = 255;

  always #5 CLK = ~CLK;

  cbu8_up_counter_if #(.WIDTH(W)) if0 ();
  cbu8_up_counter_if #(.WIDTH(W)) if_np ();
  cbu8_up_counter_if #(.WIDTH(W)) if_lo ();
  cbu8_up_counter_if #(.WIDTH(W)) if_hi ();

  assign if_hi.CAI = if_lo.CAO;

  cbu8_up_counter #(.WIDTH(W), .LOAD_PRI(1'b1)) dut    (.CLK(CLK), .CDN(CDN), .bus(if0));
  cbu8_up_counter #(.WIDTH(W), .LOAD_PRI(1'b0)) dut_np (.CLK(CLK), .CDN(CDN), .bus(if_np));
  cbu8_up_counter #(.WIDTH(W), .LOAD_PRI(1'b1)) u_lo   (.CLK(CLK), .CDN(CDN), .bus(if_lo));
  cbu8_up_counter #(.WIDTH(W), .LOAD_PRI(1'b1)) u_hi   (.CLK(CLK), .CDN(CDN), .bus(if_hi));

  function automatic int term_now();
`ifdef CBU_MODULO_EN
    return cur_mod;
`else
    return 255;
`endif
  endfunction

  // Successor of q given terminal t: terminal wraps to 0, else +1 mod 256.
  function automatic int model_next(input int q, input int t);
    if (q == t) return 0;
    return (q + 1) % 256;
  endfunction

  task automatic drive_main(input logic en, input logic cai, input logic ld, input logic [7:0] d);
    if0.EN = en; if0.CAI = cai; if0.LD = ld; if0.D = d;
  endtask

  task automatic drive_np(input logic en, input logic cai, input logic ld, input logic [7:0] d);
    if_np.EN = en; if_np.CAI = cai; if_np.LD = ld; if_np.D = d;
  endtask

  task automatic set_mod(input int m);
    cur_mod = m;
`ifdef CBU_MODULO_EN
    if0.MOD   = 8'(m);
    if_np.MOD = 8'(m);
    if_lo.MOD = 8'hFF;
    if_hi.MOD = 8'hFF;
`endif
  endtask

  task automatic test_reset();
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", if0.Q); end
    checks++; if (if0.TC !== 1'b0) begin errors++; $display("FAIL reset_tc: got %b want 0", if0.TC); end
    CDN = 1'b1;
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h00) begin errors++; $display("FAIL release_noen_q: got %h want 00", if0.Q); end
    drive_main(1'b0, 1'b0, 1'b1, 8'h59);
    @(negedge CLK);
    drive_main(1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h5A) begin errors++; $display("FAIL precount_q: got %h want 5a", if0.Q); end
    #1 CDN = 1'b0;
    #1;
    checks++; if (if0.Q !== 8'h00) begin errors++; $display("FAIL async_clr_q: got %h want 00", if0.Q); end
    checks++; if (if0.TC !== 1'b0) begin errors++; $display("FAIL async_clr_tc: got %b want 0", if0.TC); end
    checks++; if (if0.CAO !== 1'b0) begin errors++; $display("FAIL async_clr_cao: got %b want 0", if0.CAO); end
    @(negedge CLK);
    CDN = 1'b1;
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h01) begin errors++; $display("FAIL release_count_q: got %h want 01", if0.Q); end
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    drive_main(1'b0, 1'b0, 1'b1, 8'hFE);
    @(negedge CLK);
    checks++; if (if0.Q !== 8'hFE || if0.TC !== 1'b0) begin errors++; $display("FAIL wrap_load: got q=%h tc=%b want q=fe tc=0", if0.Q, if0.TC); end
    drive_main(1'b1, 1'b1, 1'b0, 8'h00);
    @(negedge CLK);
    checks++; if (if0.Q !== 8'hFF || if0.TC !== 1'b1) begin errors++; $display("FAIL wrap_edge1: got q=%h tc=%b want q=ff tc=1", if0.Q, if0.TC); end
    #1;
    checks++; if (if0.CAO !== 1'b1) begin errors++; $display("FAIL wrap_cao: got %b want 1", if0.CAO); end
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h00 || if0.TC !== 1'b0) begin errors++; $display("FAIL wrap_edge2: got q=%h tc=%b want q=00 tc=0", if0.Q, if0.TC); end
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_priority();
    drive_main(1'b0, 1'b0, 1'b1, 8'h10);
    drive_np(1'b1, 1'b0, 1'b1, 8'h44);
    @(negedge CLK);
    drive_main(1'b1, 1'b1, 1'b1, 8'h80);
    #1;
    checks++; if (if0.CAO !== 1'b0) begin errors++; $display("FAIL pri_cao: got %b want 0", if0.CAO); end
    checks++; if (if_np.Q !== 8'h44) begin errors++; $display("FAIL np_load_en: got %h want 44", if_np.Q); end
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h80) begin errors++; $display("FAIL pri_load_q: got %h want 80", if0.Q); end
    drive_main(1'b0, 1'b0, 1'b1, 8'hFF);
    @(negedge CLK);
    checks++; if (if0.TC !== 1'b1) begin errors++; $display("FAIL load_term_tc: got %b want 1", if0.TC); end
    drive_main(1'b1, 1'b1, 1'b1, 8'h33);
    #1;
    checks++; if (if0.CAO !== 1'b0) begin errors++; $display("FAIL pri_cao_at_term: got %b want 0", if0.CAO); end
    @(negedge CLK);
    checks++; if (if0.Q !== 8'h33 || if0.TC !== 1'b0) begin errors++; $display("FAIL pri_load_term: got q=%h tc=%b want q=33 tc=0", if0.Q, if0.TC); end
    drive_main(1'b0, 1'b1, 1'b1, 8'hC3);
    drive_np(1'b0, 1'b1, 1'b1, 8'hC3);
    @(negedge CLK);
    checks++; if (if0.Q !== 8'hC3) begin errors++; $display("FAIL pri1_en0_load: got %h want c3", if0.Q); end
    checks++; if (if_np.Q !== 8'h44) begin errors++; $display("FAIL pri0_en0_hold: got %h want 44", if_np.Q); end
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
    drive_np(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_hold();
    drive_main(1'b0, 1'b0, 1'b1, 8'hFF);
    @(negedge CLK);
    drive_main(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++; if (if0.Q !== 8'hFF || if0.CAO !== 1'b0 || if0.TC !== 1'b1) begin
        errors++; $display("FAIL hold_cai0: got q=%h cao=%b tc=%b want q=ff cao=0 tc=1", if0.Q, if0.CAO, if0.TC);
      end
    end
    drive_main(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      checks++; if (if0.Q !== 8'hFF || if0.CAO !== 1'b0) begin
        errors++; $display("FAIL hold_en0: got q=%h cao=%b want q=ff cao=0", if0.Q, if0.CAO);
      end
    end
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_cascade();
    if_lo.EN = 1'b1; if_lo.CAI = 1'b1; if_lo.LD = 1'b1; if_lo.D = 8'hFF;
    if_hi.EN = 1'b1; if_hi.LD = 1'b1; if_hi.D = 8'h00;
    @(negedge CLK);
    checks++; if ({if_hi.Q, if_lo.Q} !== 16'h00FF) begin errors++; $display("FAIL casc_preload: got %h want 00ff", {if_hi.Q, if_lo.Q}); end
    if_lo.LD = 1'b0; if_hi.LD = 1'b0;
    @(negedge CLK);
    checks++; if ({if_hi.Q, if_lo.Q} !== 16'h0100) begin errors++; $display("FAIL casc_step1: got %h want 0100", {if_hi.Q, if_lo.Q}); end
    repeat (255) @(negedge CLK);
    checks++; if ({if_hi.Q, if_lo.Q} !== 16'h01FF || if_lo.CAO !== 1'b1) begin
      errors++; $display("FAIL casc_01ff: got %h cao=%b want 01ff cao=1", {if_hi.Q, if_lo.Q}, if_lo.CAO);
    end
    repeat (65025) @(negedge CLK);
    checks++; if ({if_hi.Q, if_lo.Q} !== 16'h0000) begin errors++; $display("FAIL casc_wrap: got %h want 0000", {if_hi.Q, if_lo.Q}); end
    if_lo.EN = 1'b0; if_hi.EN = 1'b0;
  endtask

`ifdef CBU_MODULO_EN
  task automatic test_modulo();
    int q;
    set_mod(9);
    drive_main(1'b0, 1'b0, 1'b1, 8'd0);
    @(negedge CLK);
    drive_main(1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      checks++; if (if0.Q !== 8'(i % 10) || if0.TC !== ((i % 10) == 9)) begin
        errors++; $display("FAIL mod9_seq: got q=%0d tc=%b want q=%0d tc=%b", if0.Q, if0.TC, i % 10, ((i % 10) == 9));
      end
    end
    drive_main(1'b0, 1'b0, 1'b1, 8'd200);
    @(negedge CLK);
    drive_main(1'b1, 1'b1, 1'b0, 8'd0);
    q = 200;
    for (int i = 0; i < 66; i++) begin
      q = (q == 9) ? 0 : (q + 1) % 256;
      @(negedge CLK);
      checks++; if (if0.Q !== 8'(q) || if0.TC !== (q == 9)) begin
        errors++; $display("FAIL mod9_over: got q=%0d tc=%b want q=%0d tc=%b", if0.Q, if0.TC, q, (q == 9));
      end
    end
    drive_main(1'b0, 1'b0, 1'b0, 8'd0);
    set_mod(255);
  endtask
`endif

  task automatic test_random();
    int eq, etc, enp, etnp, t;
    logic en, cai, ld, exp_cao, exp_cao_np;
    logic [7:0] d;
    drive_main(1'b1, 1'b0, 1'b1, 8'h00);
    drive_np(1'b1, 1'b0, 1'b1, 8'h00);
    t = term_now();
    eq = 0; enp = 0; etc = (t == 0); etnp = (t == 0);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      checks++; if (if0.Q !== 8'(eq) || if0.TC !== 1'(etc)) begin
        errors++; $display("FAIL rand_pri1: got q=%h tc=%b want q=%h tc=%0d", if0.Q, if0.TC, eq, etc);
      end
      checks++; if (if_np.Q !== 8'(enp) || if_np.TC !== 1'(etnp)) begin
        errors++; $display("FAIL rand_pri0: got q=%h tc=%b want q=%h tc=%0d", if_np.Q, if_np.TC, enp, etnp);
      end
      en  = 1'($urandom_range(0, 3) != 0);
      cai = 1'($urandom_range(0, 3) != 0);
      ld  = 1'($urandom_range(0, 7) == 0);
      d   = $urandom_range(0, 1) ? 8'($urandom_range(250, 255)) : 8'($urandom);
`ifdef CBU_MODULO_EN
      set_mod($urandom_range(0, 1) ? $urandom_range(5, 12) : $urandom_range(0, 255));
`endif
      drive_main(en, cai, ld, d);
      drive_np(en, cai, ld, d);
      t = term_now();
      exp_cao    = en && cai && !ld && (eq == t);
      exp_cao_np = en && cai && !(ld && en) && (enp == t);
      #1;
      checks++; if (if0.CAO !== exp_cao || if_np.CAO !== exp_cao_np) begin
        errors++; $display("FAIL rand_cao: got %b/%b want %b/%b", if0.CAO, if_np.CAO, exp_cao, exp_cao_np);
      end
      if (ld) eq = d;
      else if (en && cai) eq = model_next(eq, t);
      etc = (eq == t);
      if (ld && en) enp = d;
      else if (en && cai) enp = model_next(enp, t);
      etnp = (enp == t);
    end
    @(negedge CLK);
    checks++; if (if0.Q !== 8'(eq) || if_np.Q !== 8'(enp)) begin
      errors++; $display("FAIL rand_final: got %h/%h want %h/%h", if0.Q, if_np.Q, eq, enp);
    end
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
    drive_np(1'b0, 1'b0, 1'b0, 8'h00);
    set_mod(255);
  endtask

  initial begin
    CDN = 1'b0;
    drive_main(1'b0, 1'b0, 1'b0, 8'h00);
    drive_np(1'b0, 1'b0, 1'b0, 8'h00);
    if_lo.EN = 1'b0; if_lo.CAI = 1'b0; if_lo.LD = 1'b0; if_lo.D = 8'h00;
    if_hi.EN = 1'b0; if_hi.LD = 1'b0; if_hi.D = 8'h00;
    set_mod(255);
    test_reset();
    test_wrap();
    test_priority();
    test_hold();
    test_cascade();
`ifdef CBU_MODULO_EN
    test_modulo();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
